// File: rtl/counter_tick_source.sv
// Count-enable generator for the binary counter: selects a prescaler, filtered
// external-edge or cascade tick source and emits a registered one-cycle enable.
module counter_tick_source #(
  parameter int unsigned PRESC_BITS = 8,
  parameter int unsigned FILT_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [1:0]            src_sel,
  input  logic [PRESC_BITS-1:0] presc,
  input  logic                  ext_in,
  input  logic [1:0]            edge_sel,
  input  logic [FILT_BITS-1:0]  filt,
  input  logic                  casc_in,
  output logic                  ena,
  output logic                  ext_lvl
);

  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SRC_PRESC = SEL_W'(0);
  localparam logic [SEL_W-1:0] SRC_EXT   = SEL_W'(1);
  localparam logic [SEL_W-1:0] SRC_CASC  = SEL_W'(2);

  localparam logic [SEL_W-1:0] EDGE_RISE = SEL_W'(0);
  localparam logic [SEL_W-1:0] EDGE_FALL = SEL_W'(1);
  localparam logic [SEL_W-1:0] EDGE_BOTH = SEL_W'(2);

  logic                  s1_q, s2_q;
  logic                  flt_q, flt_d;
  logic [FILT_BITS-1:0]  fcnt_q, fcnt_d;
  logic                  flt_dly_q;
  logic [PRESC_BITS-1:0] pcnt_q, pcnt_d;
  logic                  ena_q, ena_d;

  logic rise, fall, ext_hit;
  logic presc_act, presc_hit;
  logic sel_hit;

  // State registers; synchronizer, filter and edge delay run unconditionally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      flt_q     <= 1'b0;
      fcnt_q    <= '0;
      flt_dly_q <= 1'b0;
      pcnt_q    <= '0;
      ena_q     <= 1'b0;
    end else begin
      s1_q      <= ext_in;
      s2_q      <= s1_q;
      flt_q     <= flt_d;
      fcnt_q    <= fcnt_d;
      flt_dly_q <= flt_q;
      pcnt_q    <= pcnt_d;
      ena_q     <= ena_d;
    end
  end

  // Glitch filter: accept a new level after filt+1 consecutive differing samples
  always_comb begin
    flt_d  = flt_q;
    fcnt_d = '0;
    if (s2_q != flt_q) begin
      if (fcnt_q == filt) begin
        flt_d = s2_q;
      end else begin
        fcnt_d = fcnt_q + FILT_BITS'(1);
      end
    end
  end

  always_comb begin
    rise    = flt_q & ~flt_dly_q;
    fall    = ~flt_q & flt_dly_q;
    ext_hit = 1'b0;
    case (edge_sel)
      EDGE_RISE: ext_hit = rise;
      EDGE_FALL: ext_hit = fall;
      EDGE_BOTH: ext_hit = rise | fall;
      default:   ext_hit = 1'b0;
    endcase
  end

  // >= lets a lowered compare value tick at once instead of wrapping
  always_comb begin
    presc_act = run && (src_sel == SRC_PRESC);
    presc_hit = 1'b0;
    pcnt_d    = '0;
    if (presc_act) begin
      if (pcnt_q >= presc) begin
        presc_hit = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PRESC_BITS'(1);
      end
    end
  end

  always_comb begin
    sel_hit = 1'b0;
    case (src_sel)
      SRC_PRESC: sel_hit = presc_hit;
      SRC_EXT:   sel_hit = ext_hit;
      SRC_CASC:  sel_hit = casc_in;
      default:   sel_hit = 1'b0;
    endcase
    ena_d = run & sel_hit;
  end

  assign ena     = ena_q;
  assign ext_lvl = flt_q;

endmodule

// File: tb/tb_counter_tick_source.sv
// Self-checking bench for counter_tick_source: directed table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_counter_tick_source;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [1:0] src_sel;
  logic [7:0] presc;
  logic       ext_in;
  logic [1:0] edge_sel;
  logic [3:0] filt;
  logic       casc_in;
  logic       ena;
  logic       ext_lvl;

  int checks = 0;
  int errors = 0;

  counter_tick_source #(.PRESC_BITS(8), .FILT_BITS(4)) dut (
    .clk(clk), .rst(rst), .run(run), .src_sel(src_sel), .presc(presc),
    .ext_in(ext_in), .edge_sel(edge_sel), .filt(filt), .casc_in(casc_in),
    .ena(ena), .ext_lvl(ext_lvl)
  );

  always #5 clk = ~clk;

  // Behavioural model: sample history, run-length filter, tick-interval counter
  bit m_hist[$];
  bit m_flt, m_prev, m_ena;
  int m_diff, m_since;

  function automatic void model_reset();
    m_hist  = '{1'b0, 1'b0};
    m_flt   = 1'b0;
    m_prev  = 1'b0;
    m_ena   = 1'b0;
    m_diff  = 0;
    m_since = 0;
  endfunction

  function automatic void model_step();
    bit s2, rise, fall, ehit, active, phit, hit;
    s2   = m_hist[0];
    rise = m_flt && !m_prev;
    fall = !m_flt && m_prev;
    case (edge_sel)
      2'd0: ehit = rise;
      2'd1: ehit = fall;
      2'd2: ehit = rise || fall;
      default: ehit = 1'b0;
    endcase
    active = run && (src_sel == 2'd0);
    phit   = active && (m_since + 1 >= int'(presc) + 1);
    case (src_sel)
      2'd0: hit = phit;
      2'd1: hit = ehit;
      2'd2: hit = casc_in;
      default: hit = 1'b0;
    endcase
    m_ena  = run && hit;
    m_prev = m_flt;
    if (s2 != m_flt) begin
      m_diff++;
      if (m_diff >= int'(filt) + 1) begin
        m_flt  = s2;
        m_diff = 0;
      end
    end else begin
      m_diff = 0;
    end
    void'(m_hist.pop_front());
    m_hist.push_back(ext_in);
    m_since = !active ? 0 : (phit ? 0 : m_since + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       run;
    logic [1:0] sel;
    logic [7:0] presc;
    logic       casc;
    logic       exp_ena;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [1:0] s, input logic [7:0] p,
                              input logic c, input logic e);
    vec_t v;
    v.run = r; v.sel = s; v.presc = p; v.casc = c; v.exp_ena = e;
    tbl.push_back(v);
  endfunction

  // Apply an ext_in pulse of len cycles and record the edges at which ena is high
  task automatic ext_pulse(input int len, output int hits, output int first, output int second);
    hits = 0; first = -1; second = -1;
    ext_in = 1'b1;
    for (int i = 1; i <= len + 14; i++) begin
      tick();
      if (ena === 1'b1) begin
        if (hits == 0) first = i;
        else if (hits == 1) second = i;
        hits++;
      end
      if (i == len) ext_in = 1'b0;
    end
  endtask

  initial begin
    int hits, first, second, hold;

    // Reset held with ext_in high
    rst = 1'b0; run = 1'b0; src_sel = 2'd1; presc = 8'd3; ext_in = 1'b1;
    edge_sel = 2'd0; filt = 4'd2; casc_in = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("reset_ena", ena, 1'b0);
    chk("reset_ext_lvl", ext_lvl, 1'b0);
    rst = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("rel_ext_lvl_e%0d", i), ext_lvl, logic'(i >= 5));
      chk($sformatf("rel_no_ena_e%0d", i), ena, 1'b0);
    end
    ext_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("ext_lvl_low_settled", ext_lvl, 1'b0);
    rst = 1'b0; tick(); rst = 1'b1;

    // Directed table: prescaler, presc drop, cascade, gating, source switch
    edge_sel = 2'd3;
    for (int i = 0; i < 3; i++) add(1, 2'd0, 8'd3, 0, 0);
    add(1, 2'd0, 8'd3, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 2'd0, 8'd3, 0, 0);
    add(1, 2'd0, 8'd3, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 2'd0, 8'd3, 0, 0);
    add(1, 2'd0, 8'd1, 0, 1);
    add(1, 2'd0, 8'd1, 0, 0); add(1, 2'd0, 8'd1, 0, 1);
    add(1, 2'd0, 8'd1, 0, 0); add(1, 2'd0, 8'd1, 0, 1);
    add(1, 2'd2, 8'd3, 1, 1); add(1, 2'd2, 8'd3, 0, 0);
    add(1, 2'd3, 8'd3, 1, 0); add(0, 2'd2, 8'd3, 1, 0);
    add(1, 2'd2, 8'd3, 1, 1);
    add(1, 2'd0, 8'd3, 0, 0); add(1, 2'd0, 8'd3, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 2'd0, 8'd3, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 2'd0, 8'd3, 0, 0);
    add(1, 2'd0, 8'd3, 0, 1);
    add(1, 2'd0, 8'd3, 0, 0); add(1, 2'd0, 8'd3, 0, 0);
    add(1, 2'd1, 8'd3, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 2'd0, 8'd3, 0, 0);
    add(1, 2'd0, 8'd3, 0, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      run = tbl[i].run; src_sel = tbl[i].sel; presc = tbl[i].presc; casc_in = tbl[i].casc;
      tick();
      chk($sformatf("table_row%0d", i), ena, tbl[i].exp_ena);
    end

    // Cascade train: casc every 7 cycles reproduced one cycle later
    run = 1'b1; src_sel = 2'd2;
    for (int i = 0; i < 21; i++) begin
      casc_in = logic'(i % 7 == 0);
      tick();
      chk($sformatf("casc_c%0d", i), ena, logic'(i % 7 == 0));
    end
    casc_in = 1'b0;

    // External edge path with filt=2
    src_sel = 2'd1; filt = 4'd2; edge_sel = 2'd0;
    for (int i = 0; i < 6; i++) tick();
    ext_pulse(2, hits, first, second);
    checks++;
    if (hits != 0) begin errors++; $display("FAIL short_pulse: got %0d ena pulses expected 0", hits); end
    ext_pulse(10, hits, first, second);
    checks++;
    if (hits != 1 || first != 6) begin
      errors++; $display("FAIL rise_pulse: got %0d pulses first %0d expected 1 pulse at 6", hits, first);
    end
    edge_sel = 2'd2;
    ext_pulse(10, hits, first, second);
    checks++;
    if (hits != 2 || first != 6 || second != 16) begin
      errors++;
      $display("FAIL both_pulse: got %0d pulses at %0d,%0d expected 2 at 6,16", hits, first, second);
    end

    // Async reset during a continuous N=0 enable, then a full N+1 restart
    src_sel = 2'd0; presc = 8'd0;
    tick(); tick();
    chk("n0_ena_high", ena, 1'b1);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_ena", ena, 1'b0);
    tick();
    rst = 1'b1; presc = 8'd3;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("restart_e%0d", i), ena, logic'(i == 4));
    end

    // Randomized traffic against the model
    hold = 0;
    for (int seg = 0; seg < 8; seg++) begin
      for (int i = 0; i < 20; i++) begin
        tick();
        chk("rnd_settle_ena", ena, m_ena);
        chk("rnd_settle_lvl", ext_lvl, m_flt);
      end
      filt = 4'($urandom_range(0, 3));
      edge_sel = 2'($urandom_range(0, 3));
      for (int i = 0; i < 200; i++) begin
        if (hold == 0) begin
          ext_in = ~ext_in;
          hold = $urandom_range(1, 8);
        end
        hold--;
        run = logic'($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 15) == 0) src_sel = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) presc = 8'($urandom_range(0, 7));
        if ($urandom_range(0, 31) == 0) edge_sel = 2'($urandom_range(0, 3));
        casc_in = logic'($urandom_range(0, 3) == 0);
        tick();
        chk("rnd_ena", ena, m_ena);
        chk("rnd_ext_lvl", ext_lvl, m_flt);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_tick_source.md
# counter_tick_source

Count-enable generator placed directly upstream of the binary counter: it produces the single-cycle `ena` pulse that advances the counter. Tick sources are an internal programmable prescaler, a filtered, edge-detected external asynchronous input, or a cascade input fed from a lower counter's `ovf`. All sources are gated by `run`. `ena` is registered, so the counter sees a glitch-free, one-`clk`-wide enable.

## Interface
- PRESC_BITS, 8, width of prescaler compare value `presc`
- FILT_BITS, 4, width of glitch-filter length `filt`
- clk  input  1  clock; all logic on posedge
- rst  input  1  reset, asynchronous, active-low
- run  input  1  global tick gate; 0 suppresses `ena` and holds the prescaler at 0
- src_sel  input  2  source select: 00 prescaler, 01 external edge, 10 cascade, 11 none
- presc  input  PRESC_BITS  prescaler compare value N; tick every N+1 cycles
- ext_in  input  1  asynchronous external event input
- edge_sel  input  2  external edge type: 00 rising, 01 falling, 10 both, 11 none
- filt  input  FILT_BITS  filter length F; new level accepted after F+1 consecutive differing samples
- casc_in  input  1  synchronous cascade tick (upstream counter `ovf`)
- ena  output  1  registered count-enable pulse to the counter
- ext_lvl  output  1  filtered external level

## Operation
- Reset values: `ena`=0, `ext_lvl`=0, both synchronizer flops 0, filter counter 0, edge-delay flop 0, prescaler counter `pcnt`=0.
- **Synchronizer:** two flops, `ext_in` to `s1` to `s2`. It runs regardless of `run` and `src_sel`.
- **Filter:** `flt` drives `ext_lvl`; `fcnt` is FILT_BITS wide.
  - If `s2`==`flt`: `fcnt`<=0.
  - Else if `fcnt`==`filt`: `flt`<=`s2` and `fcnt`<=0.
  - Else: `fcnt`<=`fcnt`+1.
  - With `filt`=0, `flt` follows `s2` one cycle later.
  - A pulse shorter than F+1 cycles at `s2` never reaches `flt`.
- **Edge detect:** `flt_d`<=`flt` every cycle.
  - rise = `flt`&~`flt_d`; fall = ~`flt`&`flt_d`.
  - ext_hit is selected by `edge_sel`: rise (00), fall (01), rise|fall (10), 0 (11).
  - The filter and edge logic always run, so asserting `run` never creates a spurious edge.
- **Prescaler:** active only when `run`=1 and `src_sel`=00; otherwise `pcnt`<=0.
  - When active, if `pcnt`>=`presc`: presc_hit=1 and `pcnt`<=0.
  - Otherwise `pcnt`<=`pcnt`+1.
  - The >= comparison means that lowering `presc` below the current `pcnt` ticks on the next cycle rather than wrapping through 2^PRESC_BITS.
- **Output register:** `ena`<=`run` & sel_hit, where sel_hit is presc_hit (00), ext_hit (01), `casc_in` (10), or 0 (11).
- **Switching `src_sel` or deasserting `run`:** takes effect at the next edge. There is no pending-tick memory: events occurring while gated are discarded.

## Timing
- Prescaler, `presc`=N:
  - The first `ena` is high after the (N+1)th consecutive edge at which run=1 and src_sel=00 are sampled.
  - Subsequent pulses occur every N+1 cycles, each 1 cycle wide.
  - With N=0, `ena` is high continuously from the edge after `run` is first sampled.
- External path: `ext_in` changes before edge e1.
  - `s2` changes at e2.
  - `flt`/`ext_lvl` change at e(F+3).
  - `ena` is high from e(F+4) for exactly 1 cycle, if `run`=1 and `src_sel`=01 at e(F+4).
- Cascade: `casc_in` high at edge k gives `ena` high after edge k+1. One cycle of latency, pulse width preserved.
- Reset mid-operation: all state clears asynchronously and `ena` drops immediately. After release, the prescaler restarts a full N+1 period.
- Back-to-back external edges are limited by the filter: the minimum spacing between `ena` pulses in "both" mode is F+1 cycles.

## Test plan
- Reset with `ext_in`=1: `ena`=0 and `ext_lvl`=0 during reset. After release with filt=2, `ext_lvl` rises 5 edges later. With edge_sel=00 and run=0, no `ena` pulse occurs.
- Prescaler: run=1, src_sel=00, presc=3 → `ena` pulses at cycles 4, 8, 12, each 1 cycle wide. Drop `presc` to 1 while `pcnt`=3 → `ena` next cycle, then every 2 cycles.
- External, filt=2, edge_sel=00: a 2-cycle `ext_in` pulse gives no `ena`. A 10-cycle pulse gives one `ena`, exactly 6 edges after the rising transition. With edge_sel=10 the same pulse gives a second `ena` 6 edges after the falling transition.
- Gating: toggling `run` low for 5 cycles mid-period discards ticks. After re-assert with presc=3, the first `ena` comes after 4 cycles. Changing src_sel 00 to 01 clears `pcnt`.
- Cascade: src_sel=10, a 1-cycle `casc_in` pulse every 7 cycles → identical `ena` pulse train delayed 1 cycle. src_sel=11 → `ena` stays 0.
- Async reset asserted mid-`ena` pulse → `ena` is 0 immediately, without waiting for a `clk` edge.
